// File: rtl/wide_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wide_vec_pkg
// Brief    : Shared sizing constants and state encoding for the wide-vector
//            loader.
// Revision : 1.0 - initial release
// ============================================================================
package wide_vec_pkg;

    localparam int VEC_W     = 9984;
    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = VEC_W / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CHK  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wide_vec_loader.sv
`default_nettype none
// ============================================================================
// Module   : wide_vec_loader
// Brief    : Assembles NUM_WORDS narrow words into one VEC_W-bit vector and
//            hands it downstream over valid/ready. Define
//            WIDE_VEC_LOADER_CHECKSUM_EN to append an XOR checksum word.
// Revision : 1.0 - initial release
// ============================================================================
module wide_vec_loader
    import wide_vec_pkg::*;
(
    input  logic              sys_clk_p,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic [VEC_W-1:0]  vec_out,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic              vec_err
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_WORDS - 1);

    generate
        if ((VEC_W % WORD_W) != 0) begin : g_width_check
            $error("VEC_W must be a multiple of WORD_W");
        end
    endgenerate

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [VEC_W-1:0]   r_vec;
    logic               r_in_ready;
    logic               r_vec_valid;
    logic               w_accept;

`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]  r_acc;
    logic               r_vec_err;
`endif

    assign w_accept = in_valid & r_in_ready;

    always_ff @(posedge sys_clk_p) begin
        if (reset) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_vec       <= '0;
            r_in_ready  <= 1'b0;
            r_vec_valid <= 1'b0;
`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
            r_acc       <= '0;
            r_vec_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        // Shift in at the top so word k ends at slice k.
                        r_vec <= {in_data, r_vec[VEC_W-1:WORD_W]};
`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
                        r_acc <= r_acc ^ in_data;
`endif
                        if (r_cnt == c_last_idx) begin
                            r_cnt <= '0;
`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
                            r_state <= CHK;
`else
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_vec_valid <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_accept) begin
                        r_vec_err   <= (r_acc != in_data);
                        r_acc       <= '0;
                        r_vec_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (vec_ready) begin
                        r_vec_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign vec_out   = r_vec;
    assign vec_valid = r_vec_valid;

`ifdef WIDE_VEC_LOADER_CHECKSUM_EN
    assign vec_err = r_vec_err;
`else
    assign vec_err = 1'b0;
`endif

endmodule
`default_nettype wire
